tdm_demux_1_to_4: RTL
=====================

Name: tdm_demux_1_to_4

Overview:
- Receive end of the 4-channel time-division link. Takes a serial stream of W-bit beats, one channel per beat, with a frame marker on slot 0.
- Distributes the beats into four channel registers and publishes complete frames atomically on y0..y3.
- Pairs with the existing 4-to-1 mux path as the demultiplexing side. Uses the same slot encoding: slot index = 2*S0 + S1.

Parameters:
- W, 8, width of each channel beat and of y0..y3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present on in_data this cycle.
- in_data  input  W  beat payload.
- in_sync  input  1  qualifies the current valid beat as slot 0 of a frame. Ignored when in_valid=0.
- y0  output  W  channel 0 (slot S0=0,S1=0), last complete frame.
- y1  output  W  channel 1 (S0=0,S1=1).
- y2  output  W  channel 2 (S0=1,S1=0).
- y3  output  W  channel 3 (S0=1,S1=1).
- frame_valid  output  1  one-cycle pulse: y0..y3 just updated with a new frame.
- S0  output  1  MSB of the slot expected for the next beat.
- S1  output  1  LSB of the slot expected for the next beat.
- locked  output  1  1 while the state is LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, immediate): y0..y3=0, frame_valid=0, sync_err=0, {S0,S1}=00, locked=0, state=HUNT, staging regs=0.
- State HUNT:
  - Beats with in_sync=0 are discarded; no error is flagged.
  - A valid beat with in_sync=1 is stored in stage[0]. Next: slot=1, state=LOCKED.
- State LOCKED, valid beat at slot k:
  - k=0, in_sync=1: store stage[0], slot=1.
  - k=0, in_sync=0: lost frame. Beat discarded, sync_err pulse, state=HUNT, slot=0.
  - k=1..3, in_sync=0: store stage[k], slot=k+1 mod 4.
  - k=1..3, in_sync=1: early sync. sync_err pulse, partial frame dropped, beat stored as stage[0], slot=1, stays LOCKED.
  - k=3 normal store: on the same edge y0..y2 <= stage[0..2] and y3 <= in_data. frame_valid=1 for the cycle following that edge. Slot wraps to 0.
- in_valid=0: no state change, no outputs change, pulses deassert.
- Latency: slot-3 beat accepted at edge N. y0..y3 and frame_valid are visible after edge N, i.e. during cycle N+1.
- y0..y3 hold their values between frames. A dropped partial frame never reaches y.
- Back-to-back frames with in_valid held high give frame_valid exactly every 4th cycle.
- Reset asserted mid-frame: staged data discarded, y cleared, HUNT on release. The first frame after release requires a fresh sync.
- frame_valid and sync_err are never both 1 in the same cycle.
- S0/S1 are registered and reflect the next expected slot. In HUNT they are 00.

Test Plan:
- Reset, then beats A0(sync),A1,A2,A3 = 8'h11,22,33,44 on consecutive cycles -> cycle after 8'h44: y0..y3=11,22,33,44, frame_valid=1 for one cycle, locked=1, {S0,S1}=00.
- Idle HUNT: beats 8'h55,66 with in_sync=0, then a valid frame 01..04 -> 55/66 ignored, no sync_err, y=01,02,03,04.
- Early sync: frame 10(sync),20, then 30 with sync, 40,50,60 -> sync_err on 30, no frame_valid for 10/20, y=30,40,50,60.
- Missing sync at slot 0 after a good frame -> sync_err, locked=0, y retains the prior frame, next synced frame recovers.
- Gapped input: in_valid toggling 1,0,1,0 across a frame -> slot advances only on valid beats, correct y, single frame_valid.
- Async rst asserted after two beats of a frame -> outputs cleared immediately, HUNT. A frame without sync is then ignored, and the next synced frame is delivered.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// Receive side of the 4-channel TDM link: spreads a serial stream of W-bit beats
// over four channel registers and publishes each complete frame atomically on y0..y3.
module tdm_demux_1_to_4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_sync,
   output logic [W-1:0] y0,
   output logic [W-1:0] y1,
   output logic [W-1:0] y2,
   output logic [W-1:0] y3,
   output logic         frame_valid,
   output logic         S0,
   output logic         S1,
   output logic         locked,
   output logic         sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [1:0]   slot;
   logic [1:0]   slot_next;
   logic [W-1:0] stage0;
   logic [W-1:0] stage1;
   logic [W-1:0] stage2;
   logic [W-1:0] stage0_next;
   logic [W-1:0] stage1_next;
   logic [W-1:0] stage2_next;
   logic [W-1:0] y0_next;
   logic [W-1:0] y1_next;
   logic [W-1:0] y2_next;
   logic [W-1:0] y3_next;
   logic         frame_valid_next;
   logic         sync_err_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= HUNT;
         slot        <= 2'd0;
         stage0      <= '0;
         stage1      <= '0;
         stage2      <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state       <= state_next;
         slot        <= slot_next;
         stage0      <= stage0_next;
         stage1      <= stage1_next;
         stage2      <= stage2_next;
         y0          <= y0_next;
         y1          <= y1_next;
         y2          <= y2_next;
         y3          <= y3_next;
         frame_valid <= frame_valid_next;
         sync_err    <= sync_err_next;
      end
   end

   // Slot 3 bypasses staging: its beat goes straight to y3 so the frame lands in one edge.
   always_comb begin
      state_next       = state;
      slot_next        = slot;
      stage0_next      = stage0;
      stage1_next      = stage1;
      stage2_next      = stage2;
      y0_next          = y0;
      y1_next          = y1;
      y2_next          = y2;
      y3_next          = y3;
      frame_valid_next = 1'b0;
      sync_err_next    = 1'b0;

      if (in_valid) begin
         case (state)
            HUNT: begin
               if (in_sync) begin
                  stage0_next = in_data;
                  slot_next   = 2'd1;
                  state_next  = LOCKED;
               end
            end
            LOCKED: begin
               if (slot == 2'd0) begin
                  if (in_sync) begin
                     stage0_next = in_data;
                     slot_next   = 2'd1;
                  end else begin
                     sync_err_next = 1'b1;
                     state_next    = HUNT;
                     slot_next     = 2'd0;
                  end
               end else if (in_sync) begin
                  sync_err_next = 1'b1;
                  stage0_next   = in_data;
                  slot_next     = 2'd1;
               end else begin
                  slot_next = slot + 2'd1;
                  case (slot)
                     2'd1: stage1_next = in_data;
                     2'd2: stage2_next = in_data;
                     default: begin
                        y0_next          = stage0;
                        y1_next          = stage1;
                        y2_next          = stage2;
                        y3_next          = in_data;
                        frame_valid_next = 1'b1;
                     end
                  endcase
               end
            end
            default: begin
               state_next = HUNT;
               slot_next  = 2'd0;
            end
         endcase
      end
   end

   assign S0     = slot[1];
   assign S1     = slot[0];
   assign locked = (state == LOCKED);

endmodule
